fd_circle_window: RTL and testbench



---
 rtl/fd_pkg.sv | 25 ++
 rtl/fd_line_buffer.sv | 31 +++
 rtl/fd_circle_window.sv | 97 +++++++++
 tb/tb_fd_circle_window.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared constants, window type and circle packing for the FAST-9 front end.
package fd_pkg;

  localparam int PIX_W    = 8;
  localparam int CIRCLE_N = 16;
  localparam int RADIUS   = 3;
  localparam int WIN_N    = 2 * RADIUS + 1;

  // Circle offsets p0..p15, clockwise from the top.
  localparam int CIRC_DX [CIRCLE_N] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  localparam int CIRC_DY [CIRCLE_N] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  // win[k][c]: k = rows above the newest row (0 = newest), c = column (WIN_N-1 = newest).
  typedef logic [WIN_N-1:0][WIN_N-1:0][PIX_W-1:0] win_t;

  function automatic logic [CIRCLE_N*PIX_W-1:0] pack_circle(input win_t w);
    logic [CIRCLE_N*PIX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CIRCLE_N; i++) begin
      r[(CIRCLE_N-1-i)*PIX_W +: PIX_W] = w[RADIUS - CIRC_DY[i]][RADIUS + CIRC_DX[i]];
    end
    return r;
  endfunction

endpackage

// File: rtl/fd_line_buffer.sv
// One-line delay: dout is the pixel written DEPTH enabled cycles earlier.
module fd_line_buffer
  import fd_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Read-before-write at the same address gives exactly DEPTH cycles of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   ptr <= '0;
    else if (en) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/fd_circle_window.sv
// 7x7 window generator emitting centre + radius-3 circle pixels per interior pixel.
// Optional FD_FRAME_DONE_EN adds a frameDone pulse on the last window of a frame.
module fd_circle_window
  import fd_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PIX_W-1:0]          pixIn,
  input  logic                      pixValid,
  input  logic                      sof,
  output logic                      outValid,
  output logic [PIX_W-1:0]          refPixel,
  output logic [CIRCLE_N*PIX_W-1:0] adjPixel,
  output logic [XW-1:0]             xPos,
  output logic [YW-1:0]             yPos
`ifdef FD_FRAME_DONE_EN
  ,
  output logic                      frameDone
`endif
);

  localparam int LB_N = 2 * RADIUS;
  localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLAST = YW'(IMG_H - 1);

  logic [PIX_W-1:0] taps [LB_N+1];
  logic [XW-1:0]    col, cx;
  logic [YW-1:0]    row, cy;
  logic             emit;
  win_t             win, nwin;

  assign taps[0] = pixIn;

  for (genvar g = 0; g < LB_N; g++) begin : g_lb
    fd_line_buffer #(.DEPTH(IMG_W)) u_lb (
      .clk   (clk),
      .reset (reset),
      .en    (pixValid),
      .din   (taps[g]),
      .dout  (taps[g+1])
    );
  end

  // Outputs are taken from the post-shift window so they land one clock after acceptance.
  always_comb begin
    cx   = sof ? '0 : col;
    cy   = sof ? '0 : row;
    emit = (cx >= XW'(LB_N)) && (cy >= YW'(LB_N));
    nwin = win;
    for (int unsigned k = 0; k < WIN_N; k++) begin
      for (int unsigned c = 0; c < WIN_N - 1; c++) nwin[k][c] = win[k][c+1];
      nwin[k][WIN_N-1] = taps[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      win      <= '0;
      outValid <= 1'b0;
      refPixel <= '0;
      adjPixel <= '0;
      xPos     <= '0;
      yPos     <= '0;
`ifdef FD_FRAME_DONE_EN
      frameDone <= 1'b0;
`endif
    end else begin
      outValid <= 1'b0;
`ifdef FD_FRAME_DONE_EN
      frameDone <= 1'b0;
`endif
      if (pixValid) begin
        win <= nwin;
        col <= (cx == XLAST) ? '0 : cx + 1'b1;
        row <= (cx != XLAST) ? cy : ((cy == YLAST) ? '0 : cy + 1'b1);
        if (emit) begin
          outValid <= 1'b1;
          refPixel <= nwin[RADIUS][RADIUS];
          adjPixel <= pack_circle(nwin);
          xPos     <= cx - XW'(RADIUS);
          yPos     <= cy - YW'(RADIUS);
`ifdef FD_FRAME_DONE_EN
          frameDone <= (cx == XLAST) && (cy == YLAST);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fd_circle_window.sv
// Scoreboard bench for fd_circle_window on an 8x8 image with a positional reference model.
module tb_fd_circle_window;

  localparam int W = 8;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   pixIn = '0;
  logic         pixValid = 1'b0;
  logic         sof = 1'b0;
  logic         outValid;
  logic [7:0]   refPixel;
  logic [127:0] adjPixel;
  logic [2:0]   xPos;
  logic [2:0]   yPos;
`ifdef FD_FRAME_DONE_EN
  logic         frameDone;
`endif

  fd_circle_window #(.IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .pixIn    (pixIn),
    .pixValid (pixValid),
    .sof      (sof),
    .outValid (outValid),
    .refPixel (refPixel),
    .adjPixel (adjPixel),
    .xPos     (xPos),
    .yPos     (yPos)
`ifdef FD_FRAME_DONE_EN
    ,
    .frameDone(frameDone)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    int           x;
    int           y;
    logic [7:0]   r;
    logic [127:0] a;
    logic         fd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   npulse = 0;
  bit   chk_basic = 0;

  int         mx = 0;
  int         my = 0;
  logic [7:0] img [H][W];
  int         dxs [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int         dys [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive one cycle; on an accepted pixel update the model's picture and predict the window.
  task automatic send(input logic [7:0] v, input bit s, input bit valid);
    exp_t e;
    @(negedge clk);
    pixIn = v;
    sof = s;
    pixValid = valid;
    if (valid) begin
      if (s) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = v;
      if (mx >= 6 && my >= 6) begin
        e.cyc = cyc;
        e.x = mx - 3;
        e.y = my - 3;
        e.r = img[my-3][mx-3];
        e.a = '0;
        for (int i = 0; i < 16; i++) e.a[(15-i)*8 +: 8] = img[my-3+dys[i]][mx-3+dxs[i]];
        e.fd = (mx == W - 1) && (my == H - 1);
        q.push_back(e);
      end
      if (mx == W - 1) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] pat(input int kind, input int idx);
    logic [7:0] v;
    v = idx[7:0];
    if (kind == 1) v = 8'd255 - v;
    if (kind == 2) v = 8'($urandom);
    return v;
  endfunction

  // gap: 0 = none, 3 = idle on every third cycle, -1 = random idles
  task automatic frame(input int kind, input bit use_sof, input int gap);
    int k;
    k = 0;
    for (int idx = 0; idx < W * H; idx++) begin
      while ((gap == 3 && (k % 3) == 2) || (gap < 0 && $urandom_range(3) == 0)) begin
        send(8'h00, 1'b0, 1'b0);
        k++;
      end
      send(pat(kind, idx), use_sof && idx == 0, 1'b1);
      k++;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2 reset = 1'b1;
    q.delete();
    mx = 0;
    my = 0;
    repeat (n) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("rst_outValid", outValid, 0);
      check("rst_refPixel", refPixel, 0);
      check("rst_adjPixel", adjPixel, 0);
    end else if (outValid) begin
      npulse++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got x=%0d y=%0d expected no pulse", xPos, yPos);
      end else begin
        e = q.pop_front();
        check("latency", cyc, e.cyc + 1);
        check("xPos", xPos, e.x);
        check("yPos", yPos, e.y);
        check("refPixel", refPixel, e.r);
        check("adjPixel", adjPixel, e.a);
`ifdef FD_FRAME_DONE_EN
        check("frameDone", frameDone, e.fd);
`endif
        if (chk_basic) begin
          chk_basic = 0;
          check("basic_x", xPos, 3);
          check("basic_y", yPos, 3);
          check("basic_ref", refPixel, 27);
          check("basic_p0", adjPixel[127:120], 3);
          check("basic_p2", adjPixel[111:104], 13);
          check("basic_p4", adjPixel[95:88], 30);
          check("basic_p8", adjPixel[63:56], 51);
          check("basic_p12", adjPixel[31:24], 24);
        end
      end
    end
`ifdef FD_FRAME_DONE_EN
    else check("frameDone_idle", frameDone, 0);
`endif
  end

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Basic geometry
    chk_basic = 1;
    p0 = npulse;
    frame(0, 1'b1, 0);
    idle(2);
    check("pulses_basic", npulse - p0, 4);
    check("basic_seen", chk_basic, 0);

    // Idle gaps every third cycle
    p0 = npulse;
    frame(0, 1'b1, 3);
    idle(2);
    check("pulses_gaps", npulse - p0, 4);

    // Back-to-back frames, second inverted
    p0 = npulse;
    frame(0, 1'b1, 0);
    frame(1, 1'b1, 0);
    idle(2);
    check("pulses_b2b", npulse - p0, 8);

    // Mid-frame resync at pixel index 20
    p0 = npulse;
    for (int idx = 0; idx < 20; idx++) send(pat(0, idx), idx == 0, 1'b1);
    frame(0, 1'b1, 0);
    idle(2);
    check("pulses_resync", npulse - p0, 4);

    // Reset during row 5, then a full frame without sof
    for (int idx = 0; idx < 5 * W + 3; idx++) send(pat(2, idx), idx == 0, 1'b1);
    idle(1);
    do_reset(3);
    chk_basic = 1;
    p0 = npulse;
    frame(0, 1'b0, 0);
    idle(2);
    check("pulses_after_reset", npulse - p0, 4);

    // Random pixels with random idle gaps
    for (int f = 0; f < 4; f++) begin
      p0 = npulse;
      frame(2, 1'b1, -1);
      idle(2);
      check("pulses_random", npulse - p0, 4);
    end

    idle(3);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
